unified_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port. Arbitrates with data priority and a fetch anti-starvation limit, and sequences each access through a ready-based memory handshake. Generates byte enables and write-lane replication from the store size code and returns per-requester acknowledges. Stall outputs feed the hazard unit so IF or MEM freezes while its access is outstanding.

---
 rtl/rv32_pkg.sv | 15 +
 rtl/store_lane_gen.sv | 35 +++
 rtl/unified_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states and store size codes.
package rv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DATA  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/store_lane_gen.sv
// Byte-enable, write-lane replication and alignment check for one data access.
module store_lane_gen
    import rv32_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    // Loads always read the full word; only stores narrow the byte enables.
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                if (we_i) be_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                if (we_i) be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            SZ_WORD, 2'b11: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// with data priority bounded by an anti-starvation run limit and a ready timeout.
module unified_mem_arbiter
    import rv32_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 255
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [1:0]  dm_size_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        dm_misaligned_o,
    output logic        bus_err_o,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int RW = $clog2(MAX_DATA_RUN + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_DATA_RUN);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    arb_state_e    state_q;
    logic [RW-1:0] runCnt_q;
    logic [WW-1:0] waitCnt_q;
    logic          memReq_q;
    logic          memWe_q;
    logic [31:0]   memAddr_q;
    logic [31:0]   memWdata_q;
    logic [3:0]    memBe_q;
    logic          ifAck_q;
    logic          dmAck_q;
    logic          dmMis_q;
    logic          busErr_q;
    logic [31:0]   ifRdata_q;
    logic [31:0]   dmRdata_q;

    logic          grantData;
    logic          grantFetch;
    logic [31:0]   grantAddr;
    logic [3:0]    laneBe;
    logic [31:0]   laneWdata;
    logic          laneMis;

    // Data wins unless a waiting fetch has already watched MAX_DATA_RUN data grants go by.
    assign grantData  = dm_req_i & (~if_req_i | (runCnt_q < RUN_LIMIT));
    assign grantFetch = ~grantData & if_req_i;
    assign grantAddr  = grantData ? dm_addr_i : if_addr_i;

    store_lane_gen u_lanes (
        .size_i      (dm_size_i),
        .addr_lo_i   (grantAddr[1:0]),
        .we_i        (dm_we_i),
        .wdata_i     (dm_wdata_i),
        .be_o        (laneBe),
        .wdata_o     (laneWdata),
        .misaligned_o(laneMis)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            runCnt_q   <= '0;
            waitCnt_q  <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memBe_q    <= '0;
            ifAck_q    <= 1'b0;
            dmAck_q    <= 1'b0;
            dmMis_q    <= 1'b0;
            busErr_q   <= 1'b0;
            ifRdata_q  <= '0;
            dmRdata_q  <= '0;
        end else begin
            ifAck_q  <= 1'b0;
            dmAck_q  <= 1'b0;
            dmMis_q  <= 1'b0;
            busErr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grantData) begin
                        runCnt_q <= if_req_i ? runCnt_q + RW'(1) : '0;
                        if (laneMis) begin
                            state_q   <= ST_RESP;
                            dmAck_q   <= 1'b1;
                            dmMis_q   <= 1'b1;
                            dmRdata_q <= '0;
                        end else begin
                            state_q    <= ST_DATA;
                            memReq_q   <= 1'b1;
                            memWe_q    <= dm_we_i;
                            memAddr_q  <= {grantAddr[31:2], 2'b00};
                            memWdata_q <= laneWdata;
                            memBe_q    <= laneBe;
                        end
                    end else if (grantFetch) begin
                        runCnt_q  <= '0;
                        state_q   <= ST_FETCH;
                        memReq_q  <= 1'b1;
                        memWe_q   <= 1'b0;
                        memAddr_q <= {grantAddr[31:2], 2'b00};
                        memBe_q   <= 4'b1111;
                    end
                end
                ST_FETCH, ST_DATA: begin
                    if (mem_ready_i || (waitCnt_q == WAIT_LAST)) begin
                        memReq_q  <= 1'b0;
                        waitCnt_q <= '0;
                        state_q   <= ST_RESP;
                        busErr_q  <= ~mem_ready_i;
                        if (state_q == ST_FETCH) begin
                            ifAck_q   <= 1'b1;
                            ifRdata_q <= mem_ready_i ? mem_rdata_i : '0;
                        end else begin
                            dmAck_q   <= 1'b1;
                            dmRdata_q <= mem_ready_i ? mem_rdata_i : '0;
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q + WW'(1);
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_rdata_o      = ifRdata_q;
    assign if_ack_o        = ifAck_q;
    assign dm_rdata_o      = dmRdata_q;
    assign dm_ack_o        = dmAck_q;
    assign dm_misaligned_o = dmMis_q;
    assign bus_err_o       = busErr_q;
    assign stall_if_o      = if_req_i & ~ifAck_q;
    assign stall_mem_o     = dm_req_i & ~dmAck_q;
    assign mem_req_o       = memReq_q;
    assign mem_we_o        = memWe_q;
    assign mem_addr_o      = memAddr_q;
    assign mem_wdata_o     = memWdata_q;
    assign mem_be_o        = memBe_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with hand-computed expectations.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifAck;
    logic        dmReq;
    logic        dmWe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [1:0]  dmSize;
    logic [31:0] dmRdata;
    logic        dmAck;
    logic        dmMis;
    logic        busErr;
    logic        stallIf;
    logic        stallMem;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic [31:0] memRdata;
    logic        memReady;

    int checks = 0;
    int errors = 0;

    unified_mem_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .if_req_i       (ifReq),
        .if_addr_i      (ifAddr),
        .if_rdata_o     (ifRdata),
        .if_ack_o       (ifAck),
        .dm_req_i       (dmReq),
        .dm_we_i        (dmWe),
        .dm_addr_i      (dmAddr),
        .dm_wdata_i     (dmWdata),
        .dm_size_i      (dmSize),
        .dm_rdata_o     (dmRdata),
        .dm_ack_o       (dmAck),
        .dm_misaligned_o(dmMis),
        .bus_err_o      (busErr),
        .stall_if_o     (stallIf),
        .stall_mem_o    (stallMem),
        .mem_req_o      (memReq),
        .mem_we_o       (memWe),
        .mem_addr_o     (memAddr),
        .mem_wdata_o    (memWdata),
        .mem_be_o       (memBe),
        .mem_rdata_i    (memRdata),
        .mem_ready_i    (memReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size);
        dmReq   = req;
        dmWe    = we;
        dmAddr  = addr;
        dmWdata = wdata;
        dmSize  = size;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] grantAddrs [6];
    int          nGrants;
    logic        prevReq;

    initial begin
        rst      = 1'b1;
        ifReq    = 1'b0;
        ifAddr   = '0;
        memRdata = '0;
        memReady = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
        #12;
        checkOutput("rst_mem_req", {31'b0, memReq}, 32'd0);
        checkOutput("rst_mem_be", {28'b0, memBe}, 32'd0);
        checkOutput("rst_mem_addr", memAddr, 32'h0);
        checkOutput("rst_acks", {28'b0, ifAck, dmAck, dmMis, busErr}, 32'd0);
        checkOutput("rst_dm_rdata", dmRdata, 32'h0);
        checkOutput("rst_if_rdata", ifRdata, 32'h0);
        tick();
        rst = 1'b0;

        // Simultaneous requests: data store first, then the fetch.
        ifReq    = 1'b1;
        ifAddr   = 32'h0000_0040;
        memReady = 1'b1;
        memRdata = 32'h1111_2222;
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
        tick();
        checkOutput("t1_mem_req", {31'b0, memReq}, 32'd1);
        checkOutput("t1_mem_we", {31'b0, memWe}, 32'd1);
        checkOutput("t1_mem_be", {28'b0, memBe}, 32'hF);
        checkOutput("t1_mem_addr", memAddr, 32'h0000_0100);
        checkOutput("t1_mem_wdata", memWdata, 32'hDEAD_BEEF);
        checkOutput("t1_stalls", {30'b0, stallIf, stallMem}, 32'd3);
        tick();
        checkOutput("t1_dm_ack", {31'b0, dmAck}, 32'd1);
        checkOutput("t1_if_ack_early", {31'b0, ifAck}, 32'd0);
        checkOutput("t1_dm_rdata", dmRdata, 32'h1111_2222);
        checkOutput("t1_stall_mem_ack", {31'b0, stallMem}, 32'd0);
        dmReq = 1'b0;
        tick();
        checkOutput("t1_gap_mem_req", {31'b0, memReq}, 32'd0);
        memRdata = 32'h1357_9BDF;
        tick();
        checkOutput("t1_fetch_req", {31'b0, memReq}, 32'd1);
        checkOutput("t1_fetch_we", {31'b0, memWe}, 32'd0);
        checkOutput("t1_fetch_addr", memAddr, 32'h0000_0040);
        tick();
        checkOutput("t1_if_ack", {31'b0, ifAck}, 32'd1);
        checkOutput("t1_if_rdata", ifRdata, 32'h1357_9BDF);
        ifReq = 1'b0;
        tick();

        // Byte store to the top lane.
        applyStimulus(1'b1, 1'b1, 32'h0000_0103, 32'h0000_00A5, 2'b00);
        tick();
        checkOutput("byte_addr", memAddr, 32'h0000_0100);
        checkOutput("byte_be", {28'b0, memBe}, 32'h8);
        checkOutput("byte_wdata", memWdata, 32'hA5A5_A5A5);
        tick();
        checkOutput("byte_ack", {31'b0, dmAck}, 32'd1);
        dmReq = 1'b0;
        tick();

        // Half store to the upper half.
        applyStimulus(1'b1, 1'b1, 32'h0000_0102, 32'h0000_1234, 2'b01);
        tick();
        checkOutput("half_be", {28'b0, memBe}, 32'hC);
        checkOutput("half_wdata", memWdata, 32'h1234_1234);
        tick();
        dmReq = 1'b0;
        tick();

        // Byte load reads the whole word.
        applyStimulus(1'b1, 1'b0, 32'h0000_0202, 32'h0, 2'b00);
        tick();
        checkOutput("bload_be", {28'b0, memBe}, 32'hF);
        checkOutput("bload_we", {31'b0, memWe}, 32'd0);
        tick();
        dmReq = 1'b0;
        tick();

        // Misaligned half load is rejected without touching memory.
        applyStimulus(1'b1, 1'b0, 32'h0000_0201, 32'h0, 2'b01);
        tick();
        checkOutput("mis_ack", {30'b0, dmAck, dmMis}, 32'd3);
        checkOutput("mis_mem_req", {31'b0, memReq}, 32'd0);
        dmReq = 1'b0;
        tick();
        checkOutput("mis_pulse_end", {30'b0, dmAck, dmMis}, 32'd0);
        checkOutput("mis_mem_req_after", {31'b0, memReq}, 32'd0);

        // Both requesters held: four data grants, one fetch, then data again.
        ifReq   = 1'b1;
        ifAddr  = 32'h0000_0080;
        applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 2'b10);
        nGrants = 0;
        prevReq = 1'b0;
        for (int i = 0; i < 6; i++) grantAddrs[i] = 32'hFFFF_FFFF;
        for (int c = 0; c < 40 && nGrants < 6; c++) begin
            tick();
            if (memReq && !prevReq) begin
                grantAddrs[nGrants] = memAddr;
                nGrants++;
            end
            prevReq = memReq;
        end
        checkOutput("starve_g0", grantAddrs[0], 32'h0000_0300);
        checkOutput("starve_g3", grantAddrs[3], 32'h0000_0300);
        checkOutput("starve_g4_fetch", grantAddrs[4], 32'h0000_0080);
        checkOutput("starve_g5", grantAddrs[5], 32'h0000_0300);
        ifReq = 1'b0;
        dmReq = 1'b0;
        tick();
        tick();
        tick();

        // Three wait states, with inputs changing under the open transaction.
        memReady = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2'b10);
        tick();
        checkOutput("ws_req", {31'b0, memReq}, 32'd1);
        tick();
        dmAddr = 32'h0000_0999;
        dmWe   = 1'b1;
        tick();
        checkOutput("ws_addr_stable", memAddr, 32'h0000_0400);
        checkOutput("ws_we_stable", {31'b0, memWe}, 32'd0);
        checkOutput("ws_no_ack", {31'b0, dmAck}, 32'd0);
        tick();
        memReady = 1'b1;
        memRdata = 32'hCAFE_F00D;
        tick();
        checkOutput("ws_ack", {31'b0, dmAck}, 32'd1);
        checkOutput("ws_rdata", dmRdata, 32'hCAFE_F00D);
        checkOutput("ws_bus_err", {31'b0, busErr}, 32'd0);
        dmReq    = 1'b0;
        memReady = 1'b0;
        tick();

        // Timeout after eight idle ready cycles.
        memRdata = 32'hFFFF_FFFF;
        applyStimulus(1'b1, 1'b0, 32'h0000_0600, 32'h0, 2'b10);
        for (int c = 0; c < 8; c++) tick();
        checkOutput("to_no_ack_yet", {31'b0, dmAck}, 32'd0);
        tick();
        checkOutput("to_ack_err", {30'b0, dmAck, busErr}, 32'd3);
        checkOutput("to_rdata", dmRdata, 32'h0);
        checkOutput("to_mem_req", {31'b0, memReq}, 32'd0);
        dmReq = 1'b0;
        tick();
        checkOutput("to_err_pulse", {31'b0, busErr}, 32'd0);

        // Reset during a data access drops it without an ack.
        applyStimulus(1'b1, 1'b1, 32'h0000_0700, 32'h5555_AAAA, 2'b10);
        tick();
        checkOutput("rm_req_before", {31'b0, memReq}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rm_req_async", {31'b0, memReq}, 32'd0);
        dmReq = 1'b0;
        tick();
        checkOutput("rm_no_ack", {31'b0, dmAck}, 32'd0);
        rst      = 1'b0;
        memReady = 1'b1;
        memRdata = 32'h0BAD_F00D;
        applyStimulus(1'b1, 1'b0, 32'h0000_0704, 32'h0, 2'b10);
        tick();
        checkOutput("rm_new_req", {31'b0, memReq}, 32'd1);
        checkOutput("rm_new_addr", memAddr, 32'h0000_0704);
        tick();
        checkOutput("rm_new_ack", {31'b0, dmAck}, 32'd1);
        checkOutput("rm_new_rdata", dmRdata, 32'h0BAD_F00D);
        dmReq = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
